jt12_pm_sched: RTL and testbench

Time-multiplexes one shared combinational phase-modulation unit across all FM channels once per sample tick. Holds the per-channel fnum/pms table and owns the LFO counter that produces the 5-bit PM phase. Drives the unit's lfo_mod/fnum/pms inputs, captures each signed 9-bit offset, and streams results to the operator pipeline over a valid/ready handshake.

---
 rtl/jt12_pm_sched.sv | 163 ++++++++++++++++
 tb/tb_jt12_pm_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_pm_sched.sv
// Time-multiplexes one shared PM unit across NCH channels per sample tick; owns the LFO and channel table.
// Optional: define JT12_PM_ZEROSKIP_EN to bypass the PM unit for channels with no PM depth.
module jt12_pm_sched #(
  parameter int unsigned NCH   = 6,
  parameter int unsigned LFO_W = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        tick,
  input  logic        lfo_en,
  input  logic [2:0]  lfo_freq,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_ch,
  input  logic [10:0] cfg_fnum,
  input  logic [2:0]  cfg_pms,
  output logic [4:0]  pm_lfo_mod,
  output logic [10:0] pm_fnum,
  output logic [2:0]  pm_pms,
  input  logic [8:0]  pm_offset,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_ch,
  output logic [8:0]  res_offset,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
  localparam logic [2:0] LAST_CH = 3'(NCH - 1);

  state_t           state_q;
  logic [LFO_W-1:0] cnt_q, cnt_d;
  logic [6:0]       pre_q, pre_d, period_m1;
  logic [4:0]       snap_q;
  logic [2:0]       ch_q;
  logic [10:0]      fnum_q [NCH];
  logic [2:0]       pms_q  [NCH];
  logic [4:0]       pm_lfo_mod_q;
  logic [10:0]      pm_fnum_q;
  logic [2:0]       pm_pms_q;
  logic             res_valid_q, busy_q, overrun_q;
  logic [2:0]       res_ch_q;
  logic [8:0]       res_offset_q;
  logic             skip;

  always_comb begin
    case (lfo_freq)
      3'd0:    period_m1 = 7'd107;
      3'd1:    period_m1 = 7'd76;
      3'd2:    period_m1 = 7'd70;
      3'd3:    period_m1 = 7'd66;
      3'd4:    period_m1 = 7'd61;
      3'd5:    period_m1 = 7'd43;
      3'd6:    period_m1 = 7'd7;
      default: period_m1 = 7'd4;
    endcase
  end

  // >= so a rate change to a shorter period never leaves the prescaler past its terminal count
  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    if (!lfo_en) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (tick) begin
      if (pre_q >= period_m1) begin
        pre_d = '0;
        cnt_d = cnt_q + LFO_W'(1);
      end else begin
        pre_d = pre_q + 7'd1;
      end
    end
  end

`ifdef JT12_PM_ZEROSKIP_EN
  logic snap_en_q;
  assign skip = !snap_en_q || (pms_q[ch_q] == 3'd0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pre_q        <= '0;
      snap_q       <= '0;
      ch_q         <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        fnum_q[i] <= '0;
        pms_q[i]  <= '0;
      end
      pm_lfo_mod_q <= '0;
      pm_fnum_q    <= '0;
      pm_pms_q     <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_offset_q <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef JT12_PM_ZEROSKIP_EN
      snap_en_q    <= 1'b0;
`endif
    end else if (cen) begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      if (cfg_wr && (32'(cfg_ch) < NCH)) begin
        fnum_q[cfg_ch] <= cfg_fnum;
        pms_q[cfg_ch]  <= cfg_pms;
      end
      if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (tick) begin
          snap_q  <= cnt_q[LFO_W-1 -: 5];
`ifdef JT12_PM_ZEROSKIP_EN
          snap_en_q <= lfo_en;
`endif
          ch_q    <= '0;
          busy_q  <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: if (skip) begin
          res_offset_q <= '0;
          res_ch_q     <= ch_q;
          res_valid_q  <= 1'b1;
          state_q      <= HOLD;
        end else begin
          pm_lfo_mod_q <= snap_q;
          pm_fnum_q    <= fnum_q[ch_q];
          pm_pms_q     <= pms_q[ch_q];
          state_q      <= CAPTURE;
        end
        CAPTURE: begin
          res_offset_q <= pm_offset;
          res_ch_q     <= ch_q;
          res_valid_q  <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: if (res_valid_q && res_ready) begin
          res_valid_q <= 1'b0;
          if (ch_q == LAST_CH) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ch_q    <= ch_q + 3'd1;
            state_q <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pm_lfo_mod = pm_lfo_mod_q;
  assign pm_fnum    = pm_fnum_q;
  assign pm_pms     = pm_pms_q;
  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_offset = res_offset_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_jt12_pm_sched.sv
// Bench for jt12_pm_sched: stands in for the PM unit and scores every result against a tick-level model.
module tb_jt12_pm_sched;
  localparam int NCH   = 6;
  localparam int LFO_W = 7;
`ifdef JT12_PM_ZEROSKIP_EN
  localparam int LAT = 2, PERCH = 2;
`else
  localparam int LAT = 3, PERCH = 3;
`endif

  logic        clk, rst_n, cen, tick, lfo_en, cfg_wr, res_ready;
  logic [2:0]  lfo_freq, cfg_ch, cfg_pms, pm_pms, res_ch;
  logic [10:0] cfg_fnum, pm_fnum;
  logic [4:0]  pm_lfo_mod;
  logic [8:0]  pm_offset, res_offset;
  logic        res_valid, busy, overrun;

  jt12_pm_sched #(.NCH(NCH), .LFO_W(LFO_W)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .tick(tick), .lfo_en(lfo_en), .lfo_freq(lfo_freq),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_fnum(cfg_fnum), .cfg_pms(cfg_pms),
    .pm_lfo_mod(pm_lfo_mod), .pm_fnum(pm_fnum), .pm_pms(pm_pms), .pm_offset(pm_offset),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_offset(res_offset),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Stand-in PM unit: signed, zero for phase 0 or pms 0, sign from the phase MSB.
  function automatic logic [8:0] pm_fn(input logic [4:0] mod, input logic [10:0] fnum, input logic [2:0] pms);
    int mag;
    mag = (int'(fnum >> 4) * int'(pms) * int'(mod[3:0])) >> 6;
    return mod[4] ? 9'(-mag) : 9'(mag);
  endfunction
  assign pm_offset = pm_fn(pm_lfo_mod, pm_fnum, pm_pms);

  int errors = 0, checks = 0;
  int PER [8] = '{108, 77, 71, 67, 62, 44, 8, 5};
  int m_cnt, m_pre, m_snap, m_next_ch, results, sweeps;
  bit m_active, m_ovr, m_snap_en;
  int m_fnum [8];
  int m_pms  [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_snap = 0; m_next_ch = 0;
    m_active = 0; m_ovr = 0; m_snap_en = 0;
    for (int i = 0; i < 8; i++) begin m_fnum[i] = 0; m_pms[i] = 0; end
  endtask

  // One clock: advance the model with the inputs/outputs seen before the edge, then check after it.
  task automatic cyc();
    bit hs, pend, start;
    logic [8:0] e;
    hs    = cen && res_valid && res_ready && m_active;
    pend  = res_valid && !(cen && res_ready);
    start = 0;
    if (cen) begin
      if (tick) begin
        if (m_active) m_ovr = 1; else start = 1;
      end
      if (hs) begin
        results++;
        if (m_next_ch == NCH - 1) m_active = 0; else m_next_ch++;
      end
      if (start) begin
        m_snap = (m_cnt >> (LFO_W - 5)) & 31;
        m_snap_en = lfo_en; m_next_ch = 0; m_active = 1; sweeps++;
      end
      if (!lfo_en) begin
        m_cnt = 0; m_pre = 0;
      end else if (tick) begin
        if (m_pre >= PER[lfo_freq] - 1) begin
          m_pre = 0; m_cnt = (m_cnt + 1) % (1 << LFO_W);
        end else m_pre++;
      end
      if (cfg_wr && int'(cfg_ch) < NCH) begin
        m_fnum[cfg_ch] = int'(cfg_fnum); m_pms[cfg_ch] = int'(cfg_pms);
      end
    end
    @(posedge clk); #1;
    chk("busy", 64'(busy), 64'(m_active));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    if (pend) chk("valid_held", 64'(res_valid), 64'(1));
    if (res_valid) begin
      if (!m_active) chk("valid_while_idle", 64'(res_valid), 64'(0));
      else begin
        e = pm_fn(5'(m_snap), 11'(m_fnum[m_next_ch]), 3'(m_pms[m_next_ch]));
        chk("res_ch", 64'(res_ch), 64'(m_next_ch));
        chk("res_offset", 64'(res_offset), 64'(e));
        if (m_snap_en && m_pms[m_next_ch] != 0)
          chk("pm_drive", 64'({pm_lfo_mod, pm_fnum, pm_pms}),
              64'({5'(m_snap), 11'(m_fnum[m_next_ch]), 3'(m_pms[m_next_ch])}));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 0; cen = 1; tick = 0; cfg_wr = 0; res_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({res_valid, busy, overrun, res_ch, res_offset, pm_lfo_mod, pm_fnum, pm_pms}), 64'(0));
    model_reset();
    rst_n = 1;
  endtask

  task automatic cfg_set(input int c, input logic [10:0] f, input logic [2:0] p);
    cfg_wr = 1; cfg_ch = 3'(c); cfg_fnum = f; cfg_pms = p;
    cyc();
    cfg_wr = 0;
  endtask

  task automatic rand_table();
    for (int c = 0; c < NCH; c++)
      cfg_set(c, 11'($urandom_range(0, 2047)), 3'($urandom_range(1, 7)));
  endtask

  task automatic drain();
    cen = 1; tick = 0; cfg_wr = 0; res_ready = 1;
    for (int k = 0; k < 200 && m_active; k++) cyc();
    chk("drain_idle", 64'(busy), 64'(0));
  endtask

  task automatic wait_ch(input int c);
    for (int k = 0; k < 100; k++) begin
      if (res_valid && int'(res_ch) == c) break;
      cyc();
    end
    chk("wait_ch", 64'({res_valid, res_ch}), 64'({1'b1, 3'(c)}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, r0;
    logic [10:0] nf;
    logic [2:0]  np;
    clk = 0; rst_n = 0; cen = 1; tick = 0; lfo_en = 0; lfo_freq = 0;
    cfg_wr = 0; cfg_ch = 0; cfg_fnum = 0; cfg_pms = 0; res_ready = 1;
    results = 0; sweeps = 0;
    do_reset();

    // Full-depth table with LFO off: every offset zero, check latency and sweep length.
    for (int c = 0; c < NCH; c++) cfg_set(c, 11'h7FF, 3'd7);
    cyc();
    tick = 1; cyc(); tick = 0;
    lat = -1; bc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (lat < 0 && res_valid) lat = k;
      if (!busy) break;
      bc++;
      cyc();
    end
    chk("first_latency", 64'(lat), 64'(LAT));
    chk("sweep_busy_cycles", 64'(bc), 64'(PERCH * NCH));
    chk("sweepA_results", 64'(results), 64'(NCH));

    // 20 ticks at the fastest rate give cnt=4, phase 1.
    do_reset(); rand_table(); lfo_en = 1; lfo_freq = 7; cyc();
    tick = 1; repeat (20) cyc(); tick = 0; drain();
    chk("overrun_sticky", 64'(overrun), 64'(1));
    tick = 1; cyc(); tick = 0; drain();
    chk("pm_lfo_mod_after20", 64'(pm_lfo_mod), 64'(1));

    // Counter top and wrap: 637th tick sees cnt=127, 641st sees cnt=0.
    do_reset(); rand_table(); lfo_en = 1; lfo_freq = 7; cyc();
    tick = 1; repeat (636) cyc(); tick = 0; drain();
    tick = 1; cyc(); tick = 0; drain();
    chk("pm_lfo_mod_top", 64'(pm_lfo_mod), 64'(31));
    tick = 1; repeat (3) cyc(); tick = 0; drain();
    tick = 1; cyc(); tick = 0; drain();
    chk("pm_lfo_mod_wrap", 64'(pm_lfo_mod), 64'(0));

    // Consumer stall on ch1.
    do_reset(); rand_table(); lfo_en = 1; lfo_freq = 6; cyc();
    tick = 1; repeat (40) cyc(); tick = 0; drain();
    r0 = results;
    tick = 1; cyc(); tick = 0; wait_ch(1);
    res_ready = 0; repeat (10) cyc(); res_ready = 1; drain();
    chk("stall_results", 64'(results - r0), 64'(NCH));

    // Table write to a later channel mid-sweep, and an out-of-range write.
    r0 = results;
    tick = 1; cyc(); tick = 0; wait_ch(1);
    res_ready = 0;
    nf = 11'(m_fnum[4]) ^ 11'h555;
    np = 3'((m_pms[4] % 7) + 1);
    cfg_set(4, nf, np);
    cfg_set(7, 11'($urandom_range(0, 2047)), 3'($urandom_range(0, 7)));
    res_ready = 1; drain();
    chk("midwrite_results", 64'(results - r0), 64'(NCH));

    // cen low: tick, write and handshake all ignored.
    tick = 1; cyc(); tick = 0; wait_ch(0);
    cen = 0; tick = 1; cfg_wr = 1; cfg_ch = 3; cfg_fnum = ~11'(m_fnum[3]); cfg_pms = 3'((m_pms[3] % 7) + 1);
    repeat (5) cyc();
    cen = 1; tick = 0; cfg_wr = 0; drain();

    // Asynchronous reset in the middle of a sweep.
    tick = 1; cyc(); tick = 0; cyc(); tick = 1; cyc(); tick = 0; wait_ch(2);
    chk("overrun_before_reset", 64'(overrun), 64'(1));
    #2 rst_n = 0;
    #1;
    chk("async_reset", 64'({res_valid, busy, overrun}), 64'(0));
    @(posedge clk); #1;
    model_reset(); rst_n = 1;

    // Randomized traffic.
    lfo_en = 1; lfo_freq = 3'($urandom_range(0, 7)); rand_table(); cyc();
    r0 = results; sweeps = 0;
    for (int k = 0; k < 3000; k++) begin
      cen       = ($urandom_range(0, 7) != 0);
      tick      = ($urandom_range(0, 29) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      cfg_wr    = !m_active && ($urandom_range(0, 3) == 0);
      cfg_ch    = 3'($urandom_range(0, 7));
      cfg_fnum  = 11'($urandom_range(0, 2047));
      cfg_pms   = 3'($urandom_range(0, 7));
      cyc();
    end
    drain();
    chk("random_results", 64'(results - r0), 64'(sweeps * NCH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
